tmr_fault_manager: RTL and testbench
====================================

// Module: tmr_fault_manager
// PURPOSE
//  Sequential consumer of the TMR majority-voter comparison flags.
//  Classifies each voted ALU result, keeps per-ALU saturating error counts and
//  requests a re-execution when there is no majority.
//  Masks out an ALU that faults persistently (degraded dual mode) and raises a
//  sticky fatal error when a correct result can no longer be guaranteed.
//  Sits beside the voter in the execute stage and drives the pipeline stall/retry.
// PARAMETERS
//  CNT_W          4  width of each per-ALU saturating error counter
//  PERSIST_THRESH 3  consecutive faults by the same ALU before it is disabled (1..2^CNT_W-1)
//  RETRY_MAX      2  consecutive no-majority retries before FATAL (>=1)
// PORTS
//  clk            in   1        single clock, rising edge
//  rst_n          in   1        asynchronous active-low reset
//  result_valid   in   1        voter inputs describe a new ALU result this cycle
//  alu1_alu2_match in  1        ALU1==ALU2 flag from voter
//  alu1_alu3_match in  1        ALU1==ALU3 flag from voter
//  alu2_alu3_match in  1        ALU2==ALU3 flag from voter
//  clear_faults   in   1        sync clear: counters, mask, fatal; FSM->NORMAL
//  retry_req      out  1        1-cycle pulse: re-issue the current ALU op
//  pipe_stall     out  1        level: hold the pipeline (RETRY or FATAL)
//  alu_disable    out  3        bit i=1: ALU(i+1) excluded from voting
//  alu_err_cnt    out  3*CNT_W  packed counters, [CNT_W-1:0]=ALU1
//  fault_event    out  1        1-cycle pulse on any single-ALU fault
//  fault_alu_id   out  2        1..3 = faulting ALU, valid with fault_event; else 0
//  fatal_error    out  1        sticky until clear_faults or reset
//  fsm_state      out  2        current state encoding (debug)
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, mask 000, FSM=NORMAL; async, also mid-retry.
//  All outputs registered; response appears the cycle after result_valid.
//  Classification decodes the three match flags only, never a 2-bit status code:
//   all three =1  -> OK
//   exactly m12   -> ALU3 fault
//   exactly m13   -> ALU2 fault
//   exactly m23   -> ALU1 fault
//   none          -> NO_MAJ
//   any other combination (non-transitive) -> NO_MAJ
//  FSM states and transitions:
//   NORMAL  : single fault -> fault_event, id, cnt[id]++ (saturating), persist[id]++;
//             other ALUs' persist counters reset to 0.
//             persist[id] reaches PERSIST_THRESH -> set alu_disable bit, go to DEGRADED.
//             NO_MAJ -> retry_req pulse, retries=1, go to RETRY.
//             OK -> all persist counters reset to 0.
//   RETRY   : pipe_stall=1; wait for next result_valid.
//             Majority (OK or single fault) -> process as NORMAL and return to NORMAL, retries=0.
//             NO_MAJ and retries<RETRY_MAX -> retry_req pulse, retries++.
//             NO_MAJ and retries==RETRY_MAX -> go to FATAL.
//   DEGRADED: compare only the flag between the two enabled ALUs.
//             Match -> OK. Mismatch -> go to FATAL (no tiebreak).
//             Fault attributed to the disabled ALU is ignored; no count.
//   FATAL   : fatal_error=1, pipe_stall=1; result_valid is ignored.
//  Exit from any state only via clear_faults or rst_n.
//  clear_faults coincident with result_valid: clear wins, result discarded.
//  Counters saturate at 2^CNT_W-1; they never wrap.
//  result_valid=0: no state change, no pulses.
// STRUCTURE
//  tmr_pkg:
//   - typedef enum {NORMAL,RETRY,DEGRADED,FATAL} tmr_state_t
//   - typedef enum {OK,F_ALU1,F_ALU2,F_ALU3,NO_MAJ} tmr_fault_t
//   - ALU id constants
//  Sub-module tmr_fault_classifier: combinational flags+mask -> tmr_fault_t.
//  Top level: FSM, counters, retry counter, output registers.
// TESTING
//  1 reset, then 5 valids all-match -> counts 0, no pulses, state NORMAL, stall 0
//  2 one valid m23 only -> next cycle fault_event=1, id=1, cnt ALU1=1
//  3 three consecutive m12-only (THRESH=3) -> alu_disable=100, DEGRADED; then m12=0 -> fatal_error=1
//  4 valid none-match -> retry_req pulse, stall=1; next valid all-match -> NORMAL, stall 0
//  5 three consecutive none-match (RETRY_MAX=2) -> two retry pulses, then FATAL; clear_faults -> all 0
//  6 20 ALU2 faults interleaved with OK (CNT_W=4) -> cnt ALU2 holds 15; rst_n low mid-RETRY -> outputs 0 immediately

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared types for the TMR fault manager: FSM states, voter verdicts and ALU ids.
// fsm_state exposes tmr_state_t directly, so its encoding is part of the debug interface.
package tmr_pkg;

   typedef enum logic [1:0] {
      NORMAL   = 2'd0,
      RETRY    = 2'd1,
      DEGRADED = 2'd2,
      FATAL    = 2'd3
   } tmr_state_t;

   typedef enum logic [2:0] {
      OK     = 3'd0,
      F_ALU1 = 3'd1,
      F_ALU2 = 3'd2,
      F_ALU3 = 3'd3,
      NO_MAJ = 3'd4
   } tmr_fault_t;

   localparam logic [1:0] ALU_NONE = 2'd0;
   localparam logic [1:0] ALU1_ID  = 2'd1;
   localparam logic [1:0] ALU2_ID  = 2'd2;
   localparam logic [1:0] ALU3_ID  = 2'd3;

   // Maps a single-ALU fault verdict to its external ALU id; OK/NO_MAJ give ALU_NONE.
   function automatic logic [1:0] fault_to_id(input tmr_fault_t f);
      case (f)
         F_ALU1:  return ALU1_ID;
         F_ALU2:  return ALU2_ID;
         F_ALU3:  return ALU3_ID;
         default: return ALU_NONE;
      endcase
   endfunction

endpackage

// File: rtl/tmr_fault_manager_if.sv
// Voter-to-fault-manager bundle. The slave modport is the manager; the master
// modport is the voter/pipeline side that supplies flags and consumes stall/retry.
interface tmr_fault_manager_if #(
   parameter int unsigned CNT_W = 4
);
   logic               result_valid;
   logic               alu1_alu2_match;
   logic               alu1_alu3_match;
   logic               alu2_alu3_match;
   logic               clear_faults;
   logic               retry_req;
   logic               pipe_stall;
   logic [2:0]         alu_disable;
   logic [3*CNT_W-1:0] alu_err_cnt;
   logic               fault_event;
   logic [1:0]         fault_alu_id;
   logic               fatal_error;
   logic [1:0]         fsm_state;

   modport master (
      output result_valid, alu1_alu2_match, alu1_alu3_match, alu2_alu3_match, clear_faults,
      input  retry_req, pipe_stall, alu_disable, alu_err_cnt, fault_event, fault_alu_id,
             fatal_error, fsm_state
   );

   modport slave (
      input  result_valid, alu1_alu2_match, alu1_alu3_match, alu2_alu3_match, clear_faults,
      output retry_req, pipe_stall, alu_disable, alu_err_cnt, fault_event, fault_alu_id,
             fatal_error, fsm_state
   );
endinterface

// File: rtl/tmr_fault_classifier.sv
// Combinational verdict from the three pairwise match flags and the disable mask.
// With one ALU masked, only the flag between the two remaining ALUs matters.
module tmr_fault_classifier
   import tmr_pkg::*;
(
   input  logic       m12_i,
   input  logic       m13_i,
   input  logic       m23_i,
   input  logic [2:0] mask_i,
   output tmr_fault_t fault_o
);

   always_comb begin
      fault_o = NO_MAJ;
      unique case (mask_i)
         3'b000: begin
            case ({m12_i, m13_i, m23_i})
               3'b111:  fault_o = OK;
               3'b100:  fault_o = F_ALU3;
               3'b010:  fault_o = F_ALU2;
               3'b001:  fault_o = F_ALU1;
               // No flags, or a non-transitive pair of flags: nothing can be trusted.
               default: fault_o = NO_MAJ;
            endcase
         end
         3'b001:  fault_o = m23_i ? OK : NO_MAJ;
         3'b010:  fault_o = m13_i ? OK : NO_MAJ;
         3'b100:  fault_o = m12_i ? OK : NO_MAJ;
         default: fault_o = NO_MAJ;
      endcase
   end

endmodule

// File: rtl/tmr_fault_manager.sv
// TMR fault manager: classifies voter results, counts per-ALU faults, drives
// retry/stall, degrades to dual mode on a persistent fault and latches fatal errors.
module tmr_fault_manager
   import tmr_pkg::*;
#(
   parameter int unsigned CNT_W          = 4,
   parameter int unsigned PERSIST_THRESH = 3,
   parameter int unsigned RETRY_MAX      = 2
) (
   input logic               clk,
   input logic               rst_n,
   tmr_fault_manager_if.slave fm_if
);

   localparam int unsigned RetryW = $clog2(RETRY_MAX + 1);

   tmr_state_t                  state_q, state_d;
   logic [2:0][CNT_W-1:0]       cnt_q, cnt_d;
   logic [2:0][CNT_W-1:0]       persist_q, persist_d;
   logic [2:0]                  mask_q, mask_d;
   logic [RetryW-1:0]           retries_q, retries_d;
   logic                        retry_req_q, retry_req_d;
   logic                        fault_event_q, fault_event_d;
   logic [1:0]                  fault_id_q, fault_id_d;

   tmr_fault_t fault;
   logic [1:0] fault_id;
   logic [1:0] idx;

   tmr_fault_classifier u_classifier (
      .m12_i   (fm_if.alu1_alu2_match),
      .m13_i   (fm_if.alu1_alu3_match),
      .m23_i   (fm_if.alu2_alu3_match),
      .mask_i  (mask_q),
      .fault_o (fault)
   );

   assign fault_id = fault_to_id(fault);
   assign idx      = fault_id - 2'd1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      persist_d     = persist_q;
      mask_d        = mask_q;
      retries_d     = retries_q;
      retry_req_d   = 1'b0;
      fault_event_d = 1'b0;
      fault_id_d    = ALU_NONE;

      if (fm_if.clear_faults) begin
         state_d   = NORMAL;
         cnt_d     = '0;
         persist_d = '0;
         mask_d    = '0;
         retries_d = '0;
      end else if (fm_if.result_valid) begin
         unique case (state_q)
            NORMAL, RETRY: begin
               if (fault == NO_MAJ) begin
                  if (state_q == NORMAL) begin
                     retry_req_d = 1'b1;
                     retries_d   = RetryW'(1);
                     state_d     = RETRY;
                  end else if (retries_q < RetryW'(RETRY_MAX)) begin
                     retry_req_d = 1'b1;
                     retries_d   = retries_q + RetryW'(1);
                  end else begin
                     state_d = FATAL;
                  end
               end else begin
                  state_d   = NORMAL;
                  retries_d = '0;
                  persist_d = '0;
                  if (fault != OK) begin
                     // Only the faulting ALU keeps its run of consecutive faults.
                     persist_d[idx] = sat_inc(persist_q[idx]);
                     cnt_d[idx]     = sat_inc(cnt_q[idx]);
                     fault_event_d  = 1'b1;
                     fault_id_d     = fault_id;
                     if (persist_d[idx] >= CNT_W'(PERSIST_THRESH)) begin
                        mask_d[idx] = 1'b1;
                        state_d     = DEGRADED;
                     end
                  end
               end
            end
            DEGRADED: begin
               if (fault == NO_MAJ) state_d = FATAL;
            end
            FATAL: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= NORMAL;
         cnt_q         <= '0;
         persist_q     <= '0;
         mask_q        <= '0;
         retries_q     <= '0;
         retry_req_q   <= 1'b0;
         fault_event_q <= 1'b0;
         fault_id_q    <= ALU_NONE;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         persist_q     <= persist_d;
         mask_q        <= mask_d;
         retries_q     <= retries_d;
         retry_req_q   <= retry_req_d;
         fault_event_q <= fault_event_d;
         fault_id_q    <= fault_id_d;
      end
   end

   assign fm_if.retry_req    = retry_req_q;
   assign fm_if.pipe_stall   = (state_q == RETRY) || (state_q == FATAL);
   assign fm_if.alu_disable  = mask_q;
   assign fm_if.alu_err_cnt  = cnt_q;
   assign fm_if.fault_event  = fault_event_q;
   assign fm_if.fault_alu_id = fault_id_q;
   assign fm_if.fatal_error  = (state_q == FATAL);
   assign fm_if.fsm_state    = state_q;

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Bench for tmr_fault_manager: directed scenarios plus random flags, every cycle
// compared against a behavioural model of the fault-handling rules.
module tb_tmr_fault_manager;

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned THRESH = 3;
   localparam int unsigned RMAX   = 2;
   localparam int          SAT    = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tmr_fault_manager_if #(.CNT_W(CNT_W)) bus ();

   tmr_fault_manager #(
      .CNT_W          (CNT_W),
      .PERSIST_THRESH (THRESH),
      .RETRY_MAX      (RMAX)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fm_if (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model: 0 normal, 1 retry, 2 degraded, 3 fatal.
   int m_st;
   int m_cnt[3];
   int m_run[3];
   int m_dis[3];
   int m_retries;
   int m_retry_pulse;
   int m_fev;
   int m_id;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_retries = 0; m_retry_pulse = 0; m_fev = 0; m_id = 0;
      for (int j = 0; j < 3; j++) begin
         m_cnt[j] = 0; m_run[j] = 0; m_dis[j] = 0;
      end
   endtask

   // Flags a=ALU1/2, b=ALU1/3, c=ALU2/3. ALU numbering is 0-based inside the model.
   task automatic model_step(input bit v, input bit a, input bit b, input bit c, input bit clr);
      int bad;
      bit agree;
      m_retry_pulse = 0; m_fev = 0; m_id = 0;
      if (clr) begin
         model_reset();
      end else if (v && m_st != 3) begin
         if (m_st == 2) begin
            if (m_dis[0]) agree = c;
            else if (m_dis[1]) agree = b;
            else agree = a;
            if (!agree) m_st = 3;
         end else begin
            // -1: everyone agrees, -2: no majority, else the outvoted ALU.
            if (a && b && c) bad = -1;
            else if (a + b + c == 1) bad = a ? 2 : (b ? 1 : 0);
            else bad = -2;
            if (bad == -2) begin
               if (m_st == 0) begin
                  m_retry_pulse = 1; m_retries = 1; m_st = 1;
               end else if (m_retries < RMAX) begin
                  m_retry_pulse = 1; m_retries++;
               end else begin
                  m_st = 3;
               end
            end else begin
               m_st = 0; m_retries = 0;
               for (int j = 0; j < 3; j++) m_run[j] = (j == bad) ? m_run[j] + 1 : 0;
               if (bad >= 0) begin
                  if (m_cnt[bad] < SAT) m_cnt[bad]++;
                  m_fev = 1; m_id = bad + 1;
                  if (m_run[bad] >= THRESH) begin
                     m_dis[bad] = 1; m_st = 2;
                  end
               end
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [3*CNT_W-1:0] exp_cnt;
      logic [2:0]         exp_dis;
      for (int j = 0; j < 3; j++) begin
         exp_cnt[j*CNT_W +: CNT_W] = CNT_W'(m_cnt[j]);
         exp_dis[j]                = (m_dis[j] != 0);
      end
      check_eq({tag, ".state"},   32'(bus.fsm_state),    32'(m_st));
      check_eq({tag, ".stall"},   32'(bus.pipe_stall),   32'(m_st == 1 || m_st == 3));
      check_eq({tag, ".fatal"},   32'(bus.fatal_error),  32'(m_st == 3));
      check_eq({tag, ".retry"},   32'(bus.retry_req),    32'(m_retry_pulse));
      check_eq({tag, ".fev"},     32'(bus.fault_event),  32'(m_fev));
      check_eq({tag, ".id"},      32'(bus.fault_alu_id), 32'(m_id));
      check_eq({tag, ".disable"}, 32'(bus.alu_disable),  32'(exp_dis));
      check_eq({tag, ".cnt"},     32'(bus.alu_err_cnt),  32'(exp_cnt));
   endtask

   task automatic drive(input string tag, input bit v, input bit a, input bit b, input bit c,
                        input bit clr);
      bus.result_valid    = v;
      bus.alu1_alu2_match = a;
      bus.alu1_alu3_match = b;
      bus.alu2_alu3_match = c;
      bus.clear_faults    = clr;
      @(posedge clk);
      model_step(v, a, b, c, clr);
      #1;
      check_all(tag);
   endtask

   initial begin
      bit [2:0] f;
      bus.result_valid = 1'b0;
      bus.alu1_alu2_match = 1'b0;
      bus.alu1_alu3_match = 1'b0;
      bus.alu2_alu3_match = 1'b0;
      bus.clear_faults = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      repeat (5) drive("all_ok", 1, 1, 1, 1, 0);
      drive("alu1_fault", 1, 0, 0, 1, 0);
      drive("idle", 0, 0, 0, 0, 0);

      repeat (3) drive("alu3_persist", 1, 1, 0, 0, 0);
      drive("degraded_ok", 1, 1, 0, 0, 0);
      drive("degraded_idle", 0, 0, 0, 0, 0);
      drive("degraded_mis", 1, 0, 1, 1, 0);
      drive("fatal_ignore", 1, 1, 1, 1, 0);
      drive("clear", 0, 0, 0, 0, 1);

      drive("retry", 1, 0, 0, 0, 0);
      drive("retry_wait", 0, 0, 0, 0, 0);
      drive("retry_ok", 1, 1, 1, 1, 0);

      repeat (3) drive("retry_max", 1, 0, 0, 0, 0);
      drive("fatal_hold", 1, 0, 1, 0, 0);
      drive("clear_vs_valid", 1, 0, 0, 1, 1);
      drive("nontransitive", 1, 1, 1, 0, 0);
      drive("nontrans_ok", 1, 1, 1, 1, 0);

      for (int k = 0; k < 20; k++) begin
         drive("alu2_sat", 1, 0, 1, 0, 0);
         drive("alu2_sat_ok", 1, 1, 1, 1, 0);
      end
      drive("pre_reset_retry", 1, 0, 0, 0, 0);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int k = 0; k < 800; k++) begin
         f = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
         drive("rand", $urandom_range(0, 3) != 0, f[2], f[1], f[0],
               $urandom_range(0, 39) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
